// File: rtl/fifo_ctrl_pkg.sv
// Shared sizing helpers for the fifo_ctrl slice: depth, count width, almost-full margin.
package fifo_ctrl_pkg;

    localparam int AF_MARGIN = 2;

    function automatic int depth_of(input int depth_bits);
        return 1 << depth_bits;
    endfunction

    function automatic int cnt_width(input int depth_bits);
        return depth_bits + 1;
    endfunction

endpackage

// File: rtl/fifo_ctrl_if.sv
// Push/pop handshake and status bundle between a FIFO user (master) and fifo_ctrl (slave).
interface fifo_ctrl_if #(
    parameter int WIDTH      = 16,
    parameter int DEPTH_BITS = 3
);
    import fifo_ctrl_pkg::*;

    logic                              push;
    logic [WIDTH-1:0]                  din;
    logic                              pop;
    logic [WIDTH-1:0]                  dout;
    logic                              empty;
    logic                              full;
    logic                              almost_full;
    logic [cnt_width(DEPTH_BITS)-1:0]  count;

    modport master (output push, din, pop,
                    input  dout, empty, full, almost_full, count);
    modport slave  (input  push, din, pop,
                    output dout, empty, full, almost_full, count);
endinterface

// File: rtl/fifo_ctrl_data.sv
// Purpose: storage array for fifo_ctrl, one write port and one combinational read port.
// Latency: write lands on the rising edge; read is zero-cycle from rptr.
// Backpressure: none here; the controller only asserts wr for accepted pushes.
module fifo_data #(
    parameter int WIDTH      = 16,
    parameter int DEPTH_BITS = 3
) (
    input  logic                  clk,
    input  logic                  wr,
    input  logic [DEPTH_BITS-1:0] wptr,
    input  logic [WIDTH-1:0]      din,
    input  logic [DEPTH_BITS-1:0] rptr,
    output logic [WIDTH-1:0]      dout
);
    logic [WIDTH-1:0] mem [2**DEPTH_BITS];

    // Contents are deliberately not reset; empty qualifies dout.
    always_ff @(posedge clk) begin
        if (wr) mem[wptr] <= din;
    end

    assign dout = mem[rptr];
endmodule

// File: rtl/fifo_ctrl.sv
// Purpose: show-ahead synchronous FIFO controller; FIFO_CTRL_ERR_EN adds sticky overflow/underflow.
// Latency: pushed data appears on dout one cycle after the push into an empty queue; flags registered.
// Backpressure: push while full and pop while empty are dropped, judged on registered flags only.
module fifo_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int DEPTH_BITS = 3,
    parameter int AF_LEVEL   = depth_of(DEPTH_BITS) - AF_MARGIN
) (
    input  logic         clk,
    input  logic         rst_n,
    fifo_ctrl_if.slave   bus
`ifdef FIFO_CTRL_ERR_EN
    ,
    input  logic         err_clr,
    output logic         overflow,
    output logic         underflow
`endif
);
    localparam int              DEPTH   = depth_of(DEPTH_BITS);
    localparam int              CW      = cnt_width(DEPTH_BITS);
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0]   AF_C    = CW'(AF_LEVEL);
    localparam logic            AF_RST  = (AF_LEVEL == 0);

    logic [DEPTH_BITS-1:0] wptr, rptr;
    logic [CW-1:0]         count, count_nxt;
    logic                  empty_q, full_q, af_q;
    logic                  push_acc, pop_acc;

    assign push_acc = bus.push & ~full_q;
    assign pop_acc  = bus.pop  & ~empty_q;

    always_comb begin
        count_nxt = count;
        if (push_acc && !pop_acc)      count_nxt = count + CW'(1);
        else if (pop_acc && !push_acc) count_nxt = count - CW'(1);
    end

    // Pointers wrap naturally at DEPTH since they are exactly DEPTH_BITS wide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            af_q    <= AF_RST;
        end else begin
            if (push_acc) wptr <= wptr + 1'b1;
            if (pop_acc)  rptr <= rptr + 1'b1;
            count   <= count_nxt;
            empty_q <= (count_nxt == '0);
            full_q  <= (count_nxt == DEPTH_C);
            af_q    <= (count_nxt >= AF_C);
        end
    end

`ifdef FIFO_CTRL_ERR_EN
    // A new drop in the same cycle wins over err_clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (bus.push && full_q) overflow <= 1'b1;
            else if (err_clr)       overflow <= 1'b0;
            if (bus.pop && empty_q) underflow <= 1'b1;
            else if (err_clr)       underflow <= 1'b0;
        end
    end
`endif

    fifo_data #(
        .WIDTH      (WIDTH),
        .DEPTH_BITS (DEPTH_BITS)
    ) u_data (
        .clk  (clk),
        .wr   (push_acc),
        .wptr (wptr),
        .din  (bus.din),
        .rptr (rptr),
        .dout (bus.dout)
    );

    assign bus.empty       = empty_q;
    assign bus.full        = full_q;
    assign bus.almost_full = af_q;
    assign bus.count       = count;
endmodule

// File: tb/tb_fifo_ctrl.sv
// Scoreboarded bench for fifo_ctrl: a queue-based model predicts each post-edge state, a monitor compares.
module tb_fifo_ctrl;
    localparam int DEPTH = 8;
    localparam int AF    = DEPTH - 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
`ifdef FIFO_CTRL_ERR_EN
    logic err_clr = 1'b0;
    logic overflow, underflow;
`endif

    fifo_ctrl_if #(.WIDTH(16), .DEPTH_BITS(3)) bus ();

    fifo_ctrl #(.WIDTH(16), .DEPTH_BITS(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef FIFO_CTRL_ERR_EN
        ,
        .err_clr   (err_clr),
        .overflow  (overflow),
        .underflow (underflow)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int cnt;
        bit emp;
        bit ful;
        bit af;
        int head;
        bit ovf;
        bit udf;
    } exp_t;

    int   model_q[$];
    exp_t exp_q[$];
    bit   m_ovf = 0, m_udf = 0;
    int   chk_cnt = 0, pass_cnt = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: the FIFO as a plain queue; acceptance judged on pre-edge occupancy.
    always @(posedge clk) begin
        if (rst_n) begin
            exp_t e;
            bit push_ok, pop_ok;
            push_ok = bus.push && (model_q.size() < DEPTH);
            pop_ok  = bus.pop  && (model_q.size() > 0);
`ifdef FIFO_CTRL_ERR_EN
            if (bus.push && !push_ok) m_ovf = 1;
            else if (err_clr)         m_ovf = 0;
            if (bus.pop && !pop_ok)   m_udf = 1;
            else if (err_clr)         m_udf = 0;
`endif
            if (pop_ok)  void'(model_q.pop_front());
            if (push_ok) model_q.push_back(int'(bus.din));
            e.cnt  = model_q.size();
            e.emp  = (e.cnt == 0);
            e.ful  = (e.cnt == DEPTH);
            e.af   = (e.cnt >= AF);
            e.head = (e.cnt > 0) ? model_q[0] : -1;
            e.ovf  = m_ovf;
            e.udf  = m_udf;
            exp_q.push_back(e);
        end
    end

    always @(negedge rst_n) begin
        model_q.delete();
        exp_q.delete();
        m_ovf = 0;
        m_udf = 0;
    end

    always @(negedge clk) begin
        if (rst_n && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("count", longint'(bus.count), longint'(e.cnt));
            chk("empty", longint'(bus.empty), longint'(e.emp));
            chk("full", longint'(bus.full), longint'(e.ful));
            chk("almost_full", longint'(bus.almost_full), longint'(e.af));
            if (e.head >= 0) chk("dout", longint'(bus.dout), longint'(e.head));
`ifdef FIFO_CTRL_ERR_EN
            chk("overflow", longint'(overflow), longint'(e.ovf));
            chk("underflow", longint'(underflow), longint'(e.udf));
`endif
        end
    end

    task automatic drive(input bit p, input bit q, input logic [15:0] d);
        @(negedge clk);
        bus.push = p;
        bus.pop  = q;
        bus.din  = d;
    endtask

    initial begin
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        bus.din  = '0;
        #12;
        chk("rst_count", longint'(bus.count), 0);
        chk("rst_empty", longint'(bus.empty), 1);
        chk("rst_full", longint'(bus.full), 0);
        chk("rst_af", longint'(bus.almost_full), 0);
`ifdef FIFO_CTRL_ERR_EN
        chk("rst_ovf", longint'(overflow), 0);
        chk("rst_udf", longint'(underflow), 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Fill with 1..8 on back-to-back cycles; push into the first edge after reset.
        bus.push = 1'b1;
        bus.din  = 16'h0001;
        for (int i = 2; i <= 8; i++) drive(1, 0, 16'(i));
        drive(1, 0, 16'hDEAD);         // dropped while full
        drive(0, 0, 16'h0);
        for (int i = 0; i < 8; i++) drive(0, 1, 16'h0);
        drive(0, 1, 16'h0);            // pop on empty, dropped
        drive(0, 0, 16'h0);
`ifdef FIFO_CTRL_ERR_EN
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
`endif
        // Steady state at count 4: both pointers lap the array more than twice.
        for (int i = 0; i < 4; i++) drive(1, 0, 16'(16'h0100 + i));
        for (int i = 0; i < 20; i++) drive(1, 1, 16'(16'h0200 + i));
        for (int i = 0; i < 4; i++) drive(1, 0, 16'(16'h0300 + i));
        drive(1, 1, 16'hBEEF);         // full: pop accepted, push dropped
        drive(0, 0, 16'h0);

        for (int i = 0; i < 400; i++) begin
`ifdef FIFO_CTRL_ERR_EN
            err_clr = ($urandom_range(0, 15) == 0);
`endif
            drive($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50, 16'($urandom));
        end
`ifdef FIFO_CTRL_ERR_EN
        err_clr = 1'b0;
`endif
        for (int i = 0; i < 9; i++) drive(0, 1, 16'h0);
        for (int i = 0; i < 5; i++) drive(1, 0, 16'(16'h0500 + i));
        drive(0, 0, 16'h0);

        // Asynchronous reset mid-cycle at count 5.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count", longint'(bus.count), 0);
        chk("arst_empty", longint'(bus.empty), 1);
        chk("arst_full", longint'(bus.full), 0);
        chk("arst_af", longint'(bus.almost_full), 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.push = 1'b1;
        bus.din  = 16'h1234;
        drive(0, 0, 16'h0);
        drive(0, 1, 16'h0);
        drive(0, 0, 16'h0);
        @(negedge clk);
        @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/fifo_ctrl.md
FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 Parameter WIDTH, default 16: data width in bits.
REQ-002 Parameter DEPTH_BITS, default 3: log2 of storage depth; DEPTH = 2^DEPTH_BITS entries.
REQ-003 Parameter AF_LEVEL, default DEPTH-2: occupancy at or above which almost_full asserts.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 push  in  1  write request; din is sampled on the same edge.
REQ-007 din  in  WIDTH  write data.
REQ-008 pop  in  1  read request; consumes the entry presented on dout.
REQ-009 dout  out  WIDTH  head-of-queue data, show-ahead; valid whenever empty=0.
REQ-010 empty  out  1  registered; 1 when occupancy is 0.
REQ-011 full  out  1  registered; 1 when occupancy is DEPTH.
REQ-012 almost_full  out  1  registered; 1 when occupancy >= AF_LEVEL.
REQ-013 count  out  DEPTH_BITS+1  registered occupancy, range 0..DEPTH.

Function
REQ-014 Push is accepted iff push=1 and full=0; on acceptance the entry at wptr is written with din and wptr increments.
REQ-015 Pop is accepted iff pop=1 and empty=0; on acceptance rptr increments.
REQ-016 Acceptance uses registered full/empty only; push on full is dropped even if pop is accepted in the same cycle; pop on empty is dropped even if push is accepted in the same cycle.
REQ-017 wptr and rptr are DEPTH_BITS wide and wrap from DEPTH-1 to 0 with no gap.
REQ-018 count next = count + accepted_push - accepted_pop; an accepted simultaneous push and pop leaves count unchanged.
REQ-019 empty, full and almost_full are computed from next count and registered, so they are exact in the cycle after the edge that changed count.
REQ-020 dout is a combinational read of storage at rptr, with zero-cycle latency from rptr change; written data is visible on dout one cycle after an accepted push into an empty queue.
REQ-021 Dropped requests leave pointers, count, flags and storage unchanged.

Reset
REQ-022 On rst_n=0: wptr=0, rptr=0, count=0, empty=1, full=0, almost_full=0 (or 1 if AF_LEVEL=0); error flags=0.
REQ-023 Reset mid-operation discards all contents immediately; storage is not cleared, and dout is don't-care while empty=1.
REQ-024 The first push is accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-025 Macro FIFO_CTRL_ERR_EN: when defined, adds outputs overflow and underflow (1 bit each, sticky, reset 0), and an input err_clr (1 bit, synchronous clear).
REQ-026 With FIFO_CTRL_ERR_EN, overflow sets on a dropped push and underflow sets on a dropped pop; err_clr clears both, and a set request in the same cycle takes priority over err_clr.
REQ-027 Without FIFO_CTRL_ERR_EN, these ports and flops do not exist, and dropped requests are silent.

Structure
REQ-028 Storage is one instance of the existing sub-module fifo_data (WIDTH, DEPTH_BITS passed through); fifo_ctrl drives its rptr, wptr, wr (= accepted push) and din, and takes dout.
REQ-029 The shared package/include holds the DEPTH derivation, count-width function and default AF_LEVEL constant; nothing else is shared.

Verification
REQ-030 Reset, then push 0x0001..0x0008 on consecutive cycles (DEPTH=8) -> count 1..8, almost_full at count=6, full=1 after the 8th push, dout=0x0001.
REQ-031 From full, push 0xDEAD with no pop -> dropped, count stays 8, overflow=1 (ERR_EN); then pop 8 times -> dout sequence 0x0001..0x0008, empty=1.
REQ-032 Pop on empty -> count 0, pointers unchanged, underflow=1 (ERR_EN); err_clr=1 for one cycle -> underflow=0.
REQ-033 At count=4, push+pop for 20 cycles with incrementing data -> count constant 4, both pointers wrap at least twice, data in order.
REQ-034 Full plus simultaneous push+pop -> pop accepted, push dropped, count=7, overflow=1.
REQ-035 rst_n pulsed low asynchronously at count=5 between edges -> empty=1 and count=0 immediately, without waiting for clk.
